// File: rtl/apb_target_pkg.sv
// Shared types and helpers for the APB register-file target: FSM state encoding,
// wait-counter width and the address-window check used by the decoder.
package apb_target_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    DONE
  } apb_tgt_state_e;

  localparam int WAIT_CNT_W = 4;

  // Error if the byte address is outside [base, base+4*num_regs-1] or not word aligned.
  function automatic logic addr_window_err(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] num_regs);
    logic [31:0] last;
    last = base + (num_regs << 2) - 32'd1;
    return (addr < base) || (addr > last) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: APB byte address -> register word index plus window/alignment error.
module apb_addr_decode
  import apb_target_pkg::*;
#(
  parameter int          PADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR   = 'h400,
  parameter int unsigned NUM_REGS    = 8,
  localparam int         IDX_W       = $clog2(NUM_REGS)
) (
  input  logic [PADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]       reg_idx_o,
  output logic                   err_o
);

  logic [31:0] addr32;
  logic [31:0] base32;

  assign addr32    = 32'(addr_i);
  assign base32    = 32'(BASE_ADDR);
  // Index is only meaningful when err_o is low; otherwise it is the truncated offset.
  assign reg_idx_o = IDX_W'((addr32 - base32) >> 2);
  assign err_o     = addr_window_err(addr32, base32, 32'(NUM_REGS));

endmodule

// File: rtl/apb_reg_target.sv
// APB3 target bridging onto a word-indexed register-file back end, with programmable
// wait states and error decode. Define APB_TARGET_PSTRB_EN to add APB4 byte strobes (P_strb).
module apb_reg_target
  import apb_target_pkg::*;
#(
  parameter int          PADDR_WIDTH = 12,
  parameter int          PDATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR   = 'h400,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0,
  localparam int         IDX_W       = $clog2(NUM_REGS),
  localparam int         STRB_W      = PDATA_WIDTH / 8
) (
  input  logic                   P_clk,
  input  logic                   P_rstn,
  input  logic [PADDR_WIDTH-1:0] P_addr,
  input  logic                   P_selx,
  input  logic                   P_enable,
  input  logic                   P_write,
  input  logic [PDATA_WIDTH-1:0] P_wdata,
`ifdef APB_TARGET_PSTRB_EN
  input  logic [STRB_W-1:0]      P_strb,
`endif
  output logic                   P_ready,
  output logic                   P_slverr,
  output logic [PDATA_WIDTH-1:0] P_rdata,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [IDX_W-1:0]       reg_idx,
  output logic [PDATA_WIDTH-1:0] data_out,
  output logic [STRB_W-1:0]      wstrb,
  input  logic [PDATA_WIDTH-1:0] data_in,
  output apb_tgt_state_e         dbg_state_o
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  // Handshake: a transfer is setup (P_selx & !P_enable) followed by access cycles
  // (P_selx & P_enable) until P_ready; dropping P_selx before P_ready abandons it.
  apb_tgt_state_e         state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       reg_idx_q, reg_idx_d;
  logic [PDATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_en_q, rd_en_d;
  logic                   ready_q, ready_d;
  logic                   slverr_q, slverr_d;
  logic [PDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_err;
  logic                   strb_err;

  apb_addr_decode #(
    .PADDR_WIDTH (PADDR_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .NUM_REGS    (NUM_REGS)
  ) u_decode (
    .addr_i    (P_addr),
    .reg_idx_o (dec_idx),
    .err_o     (dec_err)
  );

`ifdef APB_TARGET_PSTRB_EN
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  assign strb_err = P_write && (P_strb == '0);
  assign wstrb_d  = (state_q == IDLE && P_selx && !P_enable) ? P_strb : wstrb_q;
  assign wstrb    = wstrb_q;

  always_ff @(posedge P_clk or negedge P_rstn) begin
    if (!P_rstn) wstrb_q <= '0;
    else         wstrb_q <= wstrb_d;
  end
`else
  assign strb_err = 1'b0;
  assign wstrb    = '1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    err_d      = err_q;
    reg_idx_d  = reg_idx_q;
    data_out_d = data_out_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    ready_d    = 1'b0;
    slverr_d   = 1'b0;
    rdata_d    = '0;
    case (state_q)
      IDLE: begin
        if (P_selx && !P_enable) begin
          write_d    = P_write;
          err_d      = dec_err || strb_err;
          reg_idx_d  = dec_idx;
          data_out_d = P_wdata;
          cnt_d      = WAIT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!P_selx) begin
          state_d = IDLE;
        end else if (P_enable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end else begin
            state_d = RESP;
            wr_en_d = write_q && !err_q;
            rd_en_d = !write_q && !err_q;
          end
        end
      end
      RESP: begin
        if (!P_selx) begin
          state_d = IDLE;
        end else begin
          ready_d  = 1'b1;
          slverr_d = err_q;
          rdata_d  = (!write_q && !err_q) ? data_in : '0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge P_clk or negedge P_rstn) begin
    if (!P_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      reg_idx_q  <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      slverr_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      err_q      <= err_d;
      reg_idx_q  <= reg_idx_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      ready_q    <= ready_d;
      slverr_q   <= slverr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign P_ready     = ready_q;
  assign P_slverr    = slverr_q;
  assign P_rdata     = rdata_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign reg_idx     = reg_idx_q;
  assign data_out    = data_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_reg_target.sv
// Bench for apb_reg_target: two instances (0 and 3 wait states) checked against a
// word-array model of the register window.
module tb_apb_reg_target;
  import apb_target_pkg::*;

  logic        clk, rstn;
  logic [11:0] p_addr;
  logic        p_write, p_enable;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic [1:0]  sel, ready, slverr, wr_en, rd_en;
  logic [31:0] rdata [2];
  logic [31:0] data_out [2];
  logic [31:0] data_in [2];
  logic [2:0]  reg_idx [2];
  logic [3:0]  wstrb [2];
  apb_tgt_state_e dbg_state [2];

  logic [31:0] bank [2][8];
  logic [31:0] mem  [2][8];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  assign data_in[0] = bank[0][reg_idx[0]];
  assign data_in[1] = bank[1][reg_idx[1]];

  apb_reg_target #(.WAIT_STATES(0)) dut0 (
    .P_clk(clk), .P_rstn(rstn), .P_addr(p_addr), .P_selx(sel[0]), .P_enable(p_enable),
    .P_write(p_write), .P_wdata(p_wdata),
`ifdef APB_TARGET_PSTRB_EN
    .P_strb(p_strb),
`endif
    .P_ready(ready[0]), .P_slverr(slverr[0]), .P_rdata(rdata[0]), .wr_en(wr_en[0]),
    .rd_en(rd_en[0]), .reg_idx(reg_idx[0]), .data_out(data_out[0]), .wstrb(wstrb[0]),
    .data_in(data_in[0]), .dbg_state_o(dbg_state[0])
  );

  apb_reg_target #(.WAIT_STATES(3)) dut3 (
    .P_clk(clk), .P_rstn(rstn), .P_addr(p_addr), .P_selx(sel[1]), .P_enable(p_enable),
    .P_write(p_write), .P_wdata(p_wdata),
`ifdef APB_TARGET_PSTRB_EN
    .P_strb(p_strb),
`endif
    .P_ready(ready[1]), .P_slverr(slverr[1]), .P_rdata(rdata[1]), .wr_en(wr_en[1]),
    .rd_en(rd_en[1]), .reg_idx(reg_idx[1]), .data_out(data_out[1]), .wstrb(wstrb[1]),
    .data_in(data_in[1]), .dbg_state_o(dbg_state[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window 0x400..0x41F, word aligned
  function automatic logic model_err(input logic [11:0] a);
    int ai;
    ai = int'(a);
    return (ai < 'h400) || (ai > 'h400 + 4 * 8 - 1) || (ai % 4 != 0);
  endfunction

  function automatic int model_idx(input logic [11:0] a);
    return (int'(a) - 'h400) / 4;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Driver: one full transfer on instance d; acts as the back end on wr_en.
  task automatic xfer(input int d, input logic [11:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic se, output int rdy_cyc,
                      output int wr_n, output int rd_n, output int stb_cyc,
                      output logic [2:0] stb_idx, output logic [31:0] stb_data);
    rd = '0; se = 1'b0; rdy_cyc = -1; wr_n = 0; rd_n = 0; stb_cyc = -1;
    stb_idx = '0; stb_data = '0;
    @(posedge clk); #1;
    sel = '0; sel[d] = 1'b1; p_enable = 1'b0; p_addr = a; p_write = w; p_wdata = wd;
    @(posedge clk); #1;
    p_enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (wr_en[d] || rd_en[d]) begin
        stb_cyc = c; stb_idx = reg_idx[d]; stb_data = data_out[d];
      end
      if (wr_en[d]) begin
        wr_n++;
        for (int b = 0; b < 4; b++)
          if (wstrb[d][b]) bank[d][reg_idx[d]][8*b +: 8] = data_out[d][8*b +: 8];
      end
      if (rd_en[d]) rd_n++;
      if (ready[d]) begin
        rdy_cyc = c; rd = rdata[d]; se = slverr[d];
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    sel = '0; p_enable = 1'b0;
  endtask

  // Runs one random-or-directed transfer and checks it fully against the model.
  task automatic run_checked(input string tag, input int d, input logic [11:0] a,
                             input logic w, input logic [31:0] wd);
    logic [31:0] rd, sd; logic se; logic [2:0] si; int rc, wn, rn, sc;
    logic e; int idx;
    e = model_err(a);
    idx = model_idx(a);
    if (!w) exp_q.push_back(e ? 32'h0 : mem[d][idx]);
    xfer(d, a, w, wd, rd, se, rc, wn, rn, sc, si, sd);
    if (w && !e) mem[d][idx] = wd;
    n_cmp++;
    if (rc !== 3 + ws_of(d)) begin
      n_err++; $display("FAIL %s ready_cycle addr=%h got %0d exp %0d", tag, a, rc, 3 + ws_of(d));
    end
    n_cmp++;
    if (se !== e) begin
      n_err++; $display("FAIL %s slverr addr=%h got %b exp %b", tag, a, se, e);
    end
    n_cmp++;
    if (wn !== ((w && !e) ? 1 : 0) || rn !== ((!w && !e) ? 1 : 0)) begin
      n_err++; $display("FAIL %s strobes addr=%h got wr=%0d rd=%0d exp wr=%0d rd=%0d", tag, a,
                        wn, rn, (w && !e) ? 1 : 0, (!w && !e) ? 1 : 0);
    end
    if (!e) begin
      n_cmp++;
      if (sc !== rc - 1 || si !== 3'(idx) || (w && sd !== wd)) begin
        n_err++; $display("FAIL %s strobe_timing addr=%h got cyc=%0d idx=%0d data=%h exp cyc=%0d idx=%0d data=%h",
                          tag, a, sc, si, sd, rc - 1, idx, wd);
      end
    end
    if (!w) begin
      logic [31:0] exp_rd;
      exp_rd = exp_q.pop_front();
      n_cmp++;
      if (rd !== exp_rd) begin
        n_err++; $display("FAIL %s rdata addr=%h got %h exp %h", tag, a, rd, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_ws;
`ifdef APB_TARGET_PSTRB_EN
    exp_ws = 4'h0;
`else
    exp_ws = 4'hF;
`endif
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ready[d] !== 1'b0 || slverr[d] !== 1'b0 || wr_en[d] !== 1'b0 || rd_en[d] !== 1'b0 ||
          rdata[d] !== 32'h0 || data_out[d] !== 32'h0 || reg_idx[d] !== 3'h0 ||
          wstrb[d] !== exp_ws || dbg_state[d] !== IDLE) begin
        n_err++; $display("FAIL reset dut%0d got rdy=%b err=%b wr=%b rd=%b rdata=%h dout=%h idx=%0d wstrb=%h exp all zero wstrb=%h",
                          d, ready[d], slverr[d], wr_en[d], rd_en[d], rdata[d], data_out[d],
                          reg_idx[d], wstrb[d], exp_ws);
      end
    end
  endtask

  task automatic test_directed();
    bank[0][7] = 32'h1234_5678;
    mem[0][7]  = 32'h1234_5678;
    run_checked("write_404", 0, 12'h404, 1'b1, 32'hA5A5_0001);
    go_idle();
    run_checked("read_41c", 0, 12'h41C, 1'b0, 32'h0);
    go_idle();
  endtask

  task automatic test_errors();
    run_checked("err_write_420", 0, 12'h420, 1'b1, 32'hDEAD_0001);
    go_idle();
    run_checked("err_read_3fc", 0, 12'h3FC, 1'b0, 32'h0);
    go_idle();
    run_checked("err_write_402", 0, 12'h402, 1'b1, 32'hDEAD_0002);
    go_idle();
    run_checked("err_read_41e", 1, 12'h41E, 1'b0, 32'h0);
    go_idle();
  endtask

  task automatic test_wait_states();
    run_checked("ws3_read_408", 1, 12'h408, 1'b0, 32'h0);
    go_idle();
    run_checked("ws3_write_418", 1, 12'h418, 1'b1, $urandom);
    go_idle();
  endtask

  // Watches n cycles on instance d for any ready or strobe.
  task automatic watch_quiet(input string tag, input int d, input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ready[d] || wr_en[d] || rd_en[d]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL %s quiet got %0d active cycles exp 0", tag, seen);
    end
  endtask

  task automatic test_abort();
    // dut0: selx dropped in first access cycle
    @(posedge clk); #1; sel = 2'b01; p_enable = 1'b0; p_addr = 12'h40C; p_write = 1'b1;
    p_wdata = 32'hBAD0_0000;
    @(posedge clk); #1; p_enable = 1'b1; sel = 2'b00;
    watch_quiet("abort_access_dut0", 0, 6);
    run_checked("after_abort_dut0", 0, 12'h40C, 1'b0, 32'h0);
    go_idle();
    // dut3: selx dropped while still counting wait states
    @(posedge clk); #1; sel = 2'b10; p_enable = 1'b0; p_addr = 12'h410; p_write = 1'b1;
    p_wdata = 32'hBAD0_0001;
    @(posedge clk); #1; p_enable = 1'b1;
    @(posedge clk); #1; sel = 2'b00;
    watch_quiet("abort_access_dut3", 1, 8);
    run_checked("after_abort_dut3", 1, 12'h410, 1'b0, 32'h0);
    go_idle();
    // dut0: selx dropped in the response cycle; the write strobe already fired
    @(posedge clk); #1; sel = 2'b01; p_enable = 1'b0; p_addr = 12'h414; p_write = 1'b1;
    p_wdata = 32'h5EED_0005;
    @(posedge clk); #1; p_enable = 1'b1;
    @(posedge clk); #1; sel = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (wr_en[0] !== 1'b1 || ready[0] !== 1'b0) begin
      n_err++; $display("FAIL abort_resp_strobe got wr=%b rdy=%b exp wr=1 rdy=0", wr_en[0], ready[0]);
    end
    bank[0][reg_idx[0]] = data_out[0];
    mem[0][5] = 32'h5EED_0005;
    watch_quiet("abort_resp_dut0", 0, 5);
    run_checked("after_abort_resp", 0, 12'h414, 1'b0, 32'h0);
    go_idle();
  endtask

  task automatic test_reset_in_resp();
    @(posedge clk); #1; sel = 2'b01; p_enable = 1'b0; p_addr = 12'h408; p_write = 1'b0;
    @(posedge clk); #1; p_enable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (rd_en[0] !== 1'b1) begin
      n_err++; $display("FAIL rst_resp_pre rd_en got %b exp 1", rd_en[0]);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (ready[0] !== 1'b0 || slverr[0] !== 1'b0 || rd_en[0] !== 1'b0 || wr_en[0] !== 1'b0 ||
        rdata[0] !== 32'h0 || reg_idx[0] !== 3'h0 || data_out[0] !== 32'h0 ||
        dbg_state[0] !== IDLE) begin
      n_err++; $display("FAIL rst_resp_outputs got rdy=%b err=%b rd=%b wr=%b rdata=%h idx=%0d dout=%h exp all zero",
                        ready[0], slverr[0], rd_en[0], wr_en[0], rdata[0], reg_idx[0], data_out[0]);
    end
    @(posedge clk); #1; sel = 2'b00; p_enable = 1'b0;
    @(negedge clk); rstn = 1'b1;
    watch_quiet("rst_resp_quiet", 0, 3);
    run_checked("after_rst_resp", 0, 12'h408, 1'b0, 32'h0);
    go_idle();
  endtask

  task automatic test_enable_in_idle();
    @(posedge clk); #1; sel = 2'b11; p_enable = 1'b1; p_addr = 12'h400; p_write = 1'b1;
    p_wdata = 32'hFFFF_0000;
    watch_quiet("enable_in_idle_dut0", 0, 6);
    n_cmp++;
    if (dbg_state[1] !== IDLE) begin
      n_err++; $display("FAIL enable_in_idle_dut3 state got %0d exp IDLE", dbg_state[1]);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [11:0] a;
      a = 12'h400 + 12'(4 * $urandom_range(0, 7));
      run_checked("b2b", i % 2, a, 1'($urandom_range(0, 1)), $urandom);
    end
    go_idle();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] a;
      int d;
      d = $urandom_range(0, 1);
      a = 12'h3F0 + 12'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_checked("random", d, a, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

`ifdef APB_TARGET_PSTRB_EN
  task automatic test_strb();
    logic [31:0] rd, sd; logic se; logic [2:0] si; int rc, wn, rn, sc;
    p_strb = 4'b0101;
    xfer(0, 12'h404, 1'b1, 32'h1122_3344, rd, se, rc, wn, rn, sc, si, sd);
    mem[0][1] = {mem[0][1][31:24], 8'h22, mem[0][1][15:8], 8'h44};
    n_cmp++;
    if (wstrb[0] !== 4'b0101 || wn !== 1 || se !== 1'b0) begin
      n_err++; $display("FAIL strb_0101 got wstrb=%b wr=%0d err=%b exp 0101 1 0", wstrb[0], wn, se);
    end
    go_idle();
    p_strb = 4'b0000;
    xfer(0, 12'h404, 1'b1, 32'hFFFF_FFFF, rd, se, rc, wn, rn, sc, si, sd);
    n_cmp++;
    if (se !== 1'b1 || wn !== 0 || rc !== 3) begin
      n_err++; $display("FAIL strb_zero got err=%b wr=%0d rdy_cyc=%0d exp 1 0 3", se, wn, rc);
    end
    go_idle();
    p_strb = 4'hF;
    run_checked("strb_readback", 0, 12'h404, 1'b0, 32'h0);
    go_idle();
  endtask
`endif

  initial begin
    rstn = 1'b0; sel = '0; p_enable = 1'b0; p_write = 1'b0; p_addr = '0; p_wdata = '0;
    p_strb = 4'hF;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        bank[d][i] = $urandom;
        mem[d][i]  = bank[d][i];
      end
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    test_reset();
    test_directed();
    test_errors();
    test_wait_states();
    test_abort();
    test_reset_in_resp();
    test_enable_in_idle();
    test_back_to_back();
`ifdef APB_TARGET_PSTRB_EN
    test_strb();
`endif
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
